// File: rtl/valid_tick_gen_if.sv
// Switch/strobe bundle between the board switch source and valid_tick_gen.
// master drives the switches; slave (the prescaler) returns the strobe and the select in effect.
interface valid_tick_gen_if;
  logic [2:0] i_sw;
  logic       o_valid;
  logic [1:0] o_sel;

  modport master (
    output i_sw,
    input  o_valid,
    input  o_sel
  );

  modport slave (
    input  i_sw,
    output o_valid,
    output o_sel
  );
endinterface

// File: rtl/valid_tick_gen.sv
// Programmable prescaler producing a one-cycle valid strobe for the LED shift stage.
// Optional 2-flop switch synchronizer enabled by defining VALID_TICK_SW_SYNC_EN.
module valid_tick_gen #(
  parameter int          NB_COUNTER = 24,
  parameter int unsigned LIMIT_0    = 8388607,
  parameter int unsigned LIMIT_1    = 4194303,
  parameter int unsigned LIMIT_2    = 2097151,
  parameter int unsigned LIMIT_3    = 1048575
) (
  input  logic            clock,
  input  logic            i_reset,
  valid_tick_gen_if.slave bus
);

  localparam logic [NB_COUNTER-1:0] LIM_0 = NB_COUNTER'(LIMIT_0);
  localparam logic [NB_COUNTER-1:0] LIM_1 = NB_COUNTER'(LIMIT_1);
  localparam logic [NB_COUNTER-1:0] LIM_2 = NB_COUNTER'(LIMIT_2);
  localparam logic [NB_COUNTER-1:0] LIM_3 = NB_COUNTER'(LIMIT_3);

  logic [2:0]            sw;
  logic                  en;
  logic [NB_COUNTER-1:0] cnt;
  logic [NB_COUNTER-1:0] limit;
  logic                  terminal;
  logic                  valid_q;
  logic [1:0]            sel_q;

`ifdef VALID_TICK_SW_SYNC_EN
  logic [2:0] sync_q1;
  logic [2:0] sync_q2;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q1 <= 3'b000;
      sync_q2 <= 3'b000;
    end else begin
      sync_q1 <= bus.i_sw;
      sync_q2 <= sync_q1;
    end
  end

  assign sw = sync_q2;
`else
  assign sw = bus.i_sw;
`endif

  assign en = sw[0];

  always_comb begin
    limit = LIM_0;
    case (sel_q)
      2'b00:   limit = LIM_0;
      2'b01:   limit = LIM_1;
      2'b10:   limit = LIM_2;
      default: limit = LIM_3;
    endcase
  end

  // >= rather than == covers a held count that exceeds a limit selected while paused.
  assign terminal = (cnt >= limit);

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      valid_q <= 1'b0;
      sel_q   <= 2'b00;
    end else if (en) begin
      valid_q <= terminal;
      if (terminal) begin
        cnt   <= '0;
        sel_q <= sw[2:1];
      end else begin
        cnt   <= cnt + NB_COUNTER'(1);
      end
    end else begin
      valid_q <= 1'b0;
      sel_q   <= sw[2:1];
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_sel   = sel_q;

endmodule

// File: tb/tb_valid_tick_gen.sv
// Scoreboard bench for valid_tick_gen with limits 3, 5, 7, 0.
// Expected strobe/select values are queued as switches are driven and popped after each edge.
module tb_valid_tick_gen;

  localparam int NB = 8;
`ifdef VALID_TICK_SW_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic       v;
    logic [1:0] s;
  } exp_t;

  logic clock = 1'b0;
  logic i_reset;

  valid_tick_gen_if bus ();

  valid_tick_gen #(
    .NB_COUNTER(NB),
    .LIMIT_0   (3),
    .LIMIT_1   (5),
    .LIMIT_2   (7),
    .LIMIT_3   (0)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc;
  int   last_pulse;
  int   first_pulse;
  logic prev_valid;

  int         lim[4] = '{3, 5, 7, 0};
  int         m_cnt;
  logic [1:0] m_sel;
  logic [2:0] m_s1;
  logic [2:0] m_s2;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt       = 0;
    m_sel       = 2'b00;
    m_s1        = 3'b000;
    m_s2        = 3'b000;
    cyc         = 0;
    last_pulse  = -1;
    first_pulse = -1;
    prev_valid  = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of switches, predict the post-edge outputs, then compare after the edge.
  task automatic apply_stimulus(input logic [2:0] s, input int exp_gap);
    exp_t       e;
    logic [2:0] eff;
    bus.i_sw = s;
`ifdef VALID_TICK_SW_SYNC_EN
    eff  = m_s2;
    m_s2 = m_s1;
    m_s1 = s;
`else
    eff  = s;
`endif
    if (eff[0]) begin
      if (m_cnt >= lim[m_sel]) begin
        m_cnt = 0;
        e.v   = 1'b1;
        m_sel = eff[2:1];
      end else begin
        m_cnt++;
        e.v = 1'b0;
      end
    end else begin
      e.v   = 1'b0;
      m_sel = eff[2:1];
    end
    e.s = m_sel;
    sb.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
    e = sb.pop_front();
    check_output("valid", 32'(bus.o_valid), 32'(e.v));
    check_output("sel", 32'(bus.o_sel), 32'(e.s));
    if (bus.o_valid && !prev_valid) begin
      if (exp_gap > 0 && last_pulse >= 0)
        check_output("pulse_gap", cyc - last_pulse, exp_gap);
      if (first_pulse < 0)
        first_pulse = cyc;
      last_pulse = cyc;
    end
    prev_valid = bus.o_valid;
  endtask

  task automatic run(input logic [2:0] s, input int n, input int exp_gap);
    for (int i = 0; i < n; i++)
      apply_stimulus(s, exp_gap);
  endtask

  task automatic run_until_pulse(input logic [2:0] s, input int budget);
    int k;
    k = 0;
    do begin
      apply_stimulus(s, 0);
      k++;
    end while (!bus.o_valid && k < budget);
    if (!bus.o_valid)
      check_output("pulse_timeout", 0, 1);
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    bus.i_sw = 3'b000;
    @(posedge clock);
    #1;
    check_output("rst_valid", 32'(bus.o_valid), 0);
    check_output("rst_sel", 32'(bus.o_sel), 0);
    i_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int highs;
    do_reset();

    // Enabled from reset with limit 3: first strobe at cycle 4, then every 4 cycles.
    run(3'b001, 17, 4);
    check_output("first_pulse", first_pulse, 4 + SYNC_LAT);

    // Mid-period select change: old period completes, then 6-cycle spacing.
    run_until_pulse(3'b001, 10);
    run(3'b001, 1, 0);
    run(3'b011, 8, 0);
    run(3'b011, 24, 6);

    // Pause with a held count, then resume from it.
    run_until_pulse(3'b011, 10);
    run(3'b011, 2, 0);
    run(3'b010, 10, 0);
    run(3'b011, 8, 0);
    run(3'b011, 14, 6);

    // Held count above the newly selected limit after a paused select change.
    run(3'b101, 8, 0);
    run_until_pulse(3'b101, 12);
    run(3'b101, 6, 0);
    run(3'b000, 3, 0);
    run(3'b001, 8, 0);
    run(3'b001, 12, 4);

    // Limit 0: continuous strobe while enabled, drops once enable clears.
    run(3'b111, 8, 0);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(3'b111, 0);
      highs += int'(bus.o_valid);
    end
    check_output("lim0_high", highs, 6);
    run(3'b110, 4, 0);

    // Asynchronous reset mid-count, without a clock edge.
    run(3'b111, 8, 0);
    #2;
    i_reset = 1'b1;
    #1;
    check_output("async_valid", 32'(bus.o_valid), 0);
    check_output("async_sel", 32'(bus.o_sel), 0);
    @(posedge clock);
    #1;
    i_reset = 1'b0;
    model_reset();
    run(3'b001, 13, 4);
    check_output("first_pulse_after_async", first_pulse, 4 + SYNC_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
